alu_wide_op_seq: RTL and testbench

Multi-cycle sequencer that runs wide (multi-chunk) arithmetic, logic and single-bit shift operations through the existing combinational `alu`, one chunk per clock. It owns the ALU's input ports while busy, chains carry between chunks and combines the per-chunk zero flags into a single wide Z. Operands up to `CHUNK_W*NUM_CHUNKS` bits are therefore handled on the narrow datapath without a second ALU.

---
 rtl/alu_wide_op_seq.sv | 191 +++++++++++++++++++
 tb/tb_alu_wide_op_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_wide_op_seq.sv
// Sequences wide add/sub/logic/single-bit-shift operations through a narrow combinational ALU,
// one chunk per clock, chaining carry and folding per-chunk Z flags into a wide Z.
module alu_wide_op_seq #(
    parameter  int CHUNK_W    = 8,
    parameter  int NUM_CHUNKS = 2,
    parameter  int OPER_W     = 4,
    localparam int FLAGS_W    = 4,
    localparam int WIDE_W     = CHUNK_W * NUM_CHUNKS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [OPER_W-1:0]  oper,
    input  logic [WIDE_W-1:0]  a_in,
    input  logic [WIDE_W-1:0]  b_in,
    input  logic               c_in,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [WIDE_W-1:0]  result,
    output logic               c_out,
    output logic               z_out,
    output logic [OPER_W-1:0]  alu_oper,
    output logic [CHUNK_W-1:0] alu_a,
    output logic [CHUNK_W-1:0] alu_b,
    output logic [FLAGS_W-1:0] alu_flags,
    input  logic [CHUNK_W-1:0] alu_out,
    input  logic [FLAGS_W-1:0] alu_flags_out
);

    localparam int IDX_W  = $clog2(NUM_CHUNKS);
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHUNKS - 1);

    localparam logic [OPER_W-1:0] OP_ADD  = OPER_W'(0);
    localparam logic [OPER_W-1:0] OP_ADC  = OPER_W'(1);
    localparam logic [OPER_W-1:0] OP_SUB  = OPER_W'(2);
    localparam logic [OPER_W-1:0] OP_SBC  = OPER_W'(3);
    localparam logic [OPER_W-1:0] OP_CMP  = OPER_W'(4);
    localparam logic [OPER_W-1:0] OP_AND  = OPER_W'(5);
    localparam logic [OPER_W-1:0] OP_ORR  = OPER_W'(6);
    localparam logic [OPER_W-1:0] OP_XOR  = OPER_W'(7);
    localparam logic [OPER_W-1:0] OP_LSL  = OPER_W'(8);
    localparam logic [OPER_W-1:0] OP_LSR  = OPER_W'(9);
    localparam logic [OPER_W-1:0] OP_ASR  = OPER_W'(10);
    localparam logic [OPER_W-1:0] OP_ROLC = OPER_W'(13);
    localparam logic [OPER_W-1:0] OP_RORC = OPER_W'(14);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    function automatic logic is_supported(input logic [OPER_W-1:0] op);
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP,
            OP_AND, OP_ORR, OP_XOR, OP_LSL, OP_LSR, OP_ASR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_msb_first(input logic [OPER_W-1:0] op);
        return (op == OP_LSR) || (op == OP_ASR);
    endfunction

    function automatic logic is_shift(input logic [OPER_W-1:0] op);
        return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR);
    endfunction

    // Later chunks switch to the carry-chaining form of the operation.
    function automatic logic [OPER_W-1:0] chunk_oper(input logic [OPER_W-1:0] op,
                                                     input logic first);
        case (op)
            OP_ADD:  return first ? OP_ADD : OP_ADC;
            OP_SUB:  return first ? OP_SUB : OP_SBC;
            OP_CMP:  return first ? OP_CMP : OP_SBC;
            OP_LSL:  return first ? OP_LSL : OP_ROLC;
            OP_LSR:  return first ? OP_LSR : OP_RORC;
            OP_ASR:  return first ? OP_ASR : OP_RORC;
            default: return op;
        endcase
    endfunction

    state_t                            state;
    logic [IDX_W-1:0]                  idx;
    logic                              carry_reg;
    logic                              z_acc;
    logic [OPER_W-1:0]                 oper_reg;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] a_reg;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] b_reg;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] res_reg;
    logic                              c_reg;
    logic                              z_reg;
    logic                              done_reg;
    logic                              err_reg;

    logic msb_first;
    logic first_chunk;
    logic last_chunk;
    logic alu_c;
    logic alu_z;
    logic unused_flags;

    assign msb_first    = is_msb_first(oper_reg);
    assign first_chunk  = msb_first ? (idx == IDX_LAST) : (idx == '0);
    assign last_chunk   = msb_first ? (idx == '0) : (idx == IDX_LAST);
    assign alu_c        = alu_flags_out[FLAG_C];
    assign alu_z        = alu_flags_out[FLAG_Z];
    assign unused_flags = ^alu_flags_out[FLAGS_W-1:2];

    assign busy   = (state != S_IDLE);
    assign done   = done_reg;
    assign err    = err_reg;
    assign result = res_reg;
    assign c_out  = c_reg;
    assign z_out  = z_reg;

    // ALU inputs follow the registered chunk index in the same cycle; idle otherwise.
    always_comb begin
        alu_oper  = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_flags = '0;
        if (state == S_RUN) begin
            alu_oper          = chunk_oper(oper_reg, first_chunk);
            alu_a             = a_reg[idx];
            alu_b             = is_shift(oper_reg) ? CHUNK_W'(1) : b_reg[idx];
            alu_flags[FLAG_C] = carry_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            z_acc     <= 1'b0;
            oper_reg  <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            c_reg     <= 1'b0;
            z_reg     <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    err_reg  <= 1'b0;
                    if (start) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        oper_reg  <= oper;
                        carry_reg <= c_in;
                        z_acc     <= 1'b1;
                        if (is_supported(oper)) begin
                            state <= S_RUN;
                            idx   <= is_msb_first(oper) ? IDX_LAST : '0;
                        end else begin
                            state    <= S_DONE;
                            done_reg <= 1'b1;
                            err_reg  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    carry_reg <= alu_c;
                    z_acc     <= z_acc & alu_z;
                    if (oper_reg != OP_CMP) begin
                        res_reg[idx] <= alu_out;
                    end
                    if (last_chunk) begin
                        c_reg    <= alu_c;
                        z_reg    <= z_acc & alu_z;
                        done_reg <= 1'b1;
                        err_reg  <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        idx <= msb_first ? (idx - 1'b1) : (idx + 1'b1);
                    end
                end
                S_DONE: begin
                    done_reg <= 1'b0;
                    err_reg  <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_op_seq.sv
// Table-driven bench for alu_wide_op_seq with a behavioural model of the narrow ALU.
module tb_alu_wide_op_seq;

    localparam int CW = 8;
    localparam int N  = 2;
    localparam int W  = CW * N;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADC  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SBC  = 4'd3;
    localparam logic [3:0] OP_CMP  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_ORR  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_LSL  = 4'd8;
    localparam logic [3:0] OP_LSR  = 4'd9;
    localparam logic [3:0] OP_ASR  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_ROLC = 4'd13;
    localparam logic [3:0] OP_RORC = 4'd14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    oper = '0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          c_in = 1'b0;
    logic          busy, done, err, c_out, z_out;
    logic [W-1:0]  result;
    logic [3:0]    alu_oper;
    logic [CW-1:0] alu_a, alu_b, alu_out;
    logic [3:0]    alu_flags, alu_flags_out;

    alu_wide_op_seq #(.CHUNK_W(CW), .NUM_CHUNKS(N), .OPER_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .oper(oper),
        .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .busy(busy), .done(done), .err(err), .result(result),
        .c_out(c_out), .z_out(z_out),
        .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_flags(alu_flags),
        .alu_out(alu_out), .alu_flags_out(alu_flags_out)
    );

    always #5 clk = ~clk;

    // Narrow ALU model: flags bit0 = C, bit1 = Z; C=1 means no borrow.
    always_comb begin
        logic [CW:0] s;
        logic        ci;
        ci = alu_flags[0];
        s  = '0;
        case (alu_oper)
            OP_ADD:         s = {1'b0, alu_a} + {1'b0, alu_b};
            OP_ADC:         s = {1'b0, alu_a} + {1'b0, alu_b} + {{CW{1'b0}}, ci};
            OP_SUB, OP_CMP: s = {1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1;
            OP_SBC:         s = {1'b0, alu_a} + {1'b0, ~alu_b} + {{CW{1'b0}}, ci};
            OP_AND:         s = {ci, alu_a & alu_b};
            OP_ORR:         s = {ci, alu_a | alu_b};
            OP_XOR:         s = {ci, alu_a ^ alu_b};
            OP_LSL:         s = {alu_a[CW-1], alu_a[CW-2:0], 1'b0};
            OP_ROLC:        s = {alu_a[CW-1], alu_a[CW-2:0], ci};
            OP_LSR:         s = {alu_a[0], 1'b0, alu_a[CW-1:1]};
            OP_ASR:         s = {alu_a[0], alu_a[CW-1], alu_a[CW-1:1]};
            OP_RORC:        s = {alu_a[0], ci, alu_a[CW-1:1]};
            default:        s = '0;
        endcase
        alu_out       = s[CW-1:0];
        alu_flags_out = {2'b00, (s[CW-1:0] == '0), s[CW]};
    end

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic         c;
        logic         z;
    } vec_t;

    vec_t vecs[14];
    int   n_applied = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation; start stays high for 'hold' accept-side edges. Samples 8 edges.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input int hold,
                          output int lat, output int busy_n, output int done_n,
                          output int bad_b, output int last_done,
                          output logic [W-1:0] r, output logic c, output logic z,
                          output logic e);
        lat = 0; busy_n = 0; done_n = 0; bad_b = 0; last_done = -1;
        r = '0; c = 1'b0; z = 1'b0; e = 1'b0;
        @(negedge clk);
        oper = op; a_in = a; b_in = b; c_in = cin; start = 1'b1;
        for (int s = 0; s < 8; s++) begin
            @(posedge clk);
            #1;
            if (busy) busy_n++;
            if (busy && !done && (op == OP_LSL || op == OP_LSR || op == OP_ASR) && alu_b != 8'd1)
                bad_b++;
            if (done) begin
                done_n++;
                last_done = s;
                if (lat == 0) begin
                    lat = s + 1;
                    r = result; c = c_out; z = z_out; e = err;
                end
            end
            @(negedge clk);
            if (s + 1 >= hold) start = 1'b0;
            else a_in = ~a;
        end
        start = 1'b0;
    endtask

    initial begin
        int lat, busy_n, done_n, bad_b, last_done;
        logic [W-1:0] r, prev;
        logic c, z, e;

        vecs[0]  = '{OP_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{OP_SUB, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b1, 1'b0};
        vecs[2]  = '{OP_SBC, 16'h0005, 16'h0005, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[3]  = '{OP_LSL, 16'h8081, 16'h0000, 1'b0, 16'h0102, 1'b1, 1'b0};
        vecs[4]  = '{OP_LSR, 16'h0101, 16'h0000, 1'b0, 16'h0080, 1'b1, 1'b0};
        vecs[5]  = '{OP_ASR, 16'h8001, 16'h0000, 1'b0, 16'hC000, 1'b1, 1'b0};
        vecs[6]  = '{OP_ADD, 16'hBE00, 16'h00EF, 1'b0, 16'hBEEF, 1'b0, 1'b0};
        vecs[7]  = '{OP_CMP, 16'h1234, 16'h1234, 1'b0, 16'hBEEF, 1'b1, 1'b1};
        vecs[8]  = '{OP_CMP, 16'h1200, 16'h1234, 1'b0, 16'hBEEF, 1'b0, 1'b0};
        vecs[9]  = '{OP_AND, 16'hF00F, 16'h0FF0, 1'b1, 16'h0000, 1'b1, 1'b1};
        vecs[10] = '{OP_XOR, 16'hFF00, 16'h00FF, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[11] = '{OP_ORR, 16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b0, 1'b0};
        vecs[12] = '{OP_ADC, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};
        vecs[13] = '{OP_ADD, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", {16'd0, result}, 32'd0);
        check("reset_alu_side", {12'd0, alu_oper, alu_a, alu_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, 1,
                   lat, busy_n, done_n, bad_b, last_done, r, c, z, e);
            check($sformatf("v%0d_result", i), {16'd0, r}, {16'd0, vecs[i].res});
            check($sformatf("v%0d_c", i), {31'd0, c}, {31'd0, vecs[i].c});
            check($sformatf("v%0d_z", i), {31'd0, z}, {31'd0, vecs[i].z});
            check($sformatf("v%0d_err", i), {31'd0, e}, 32'd0);
            check($sformatf("v%0d_latency", i), lat, 3);
            check($sformatf("v%0d_done_count", i), done_n, 1);
            check($sformatf("v%0d_busy_cycles", i), busy_n, 3);
            check($sformatf("v%0d_shift_alu_b", i), bad_b, 0);
        end

        // start held through RUN: ignored, operands not recaptured
        run_op(OP_ADD, 16'h0102, 16'h0304, 1'b0, 2,
               lat, busy_n, done_n, bad_b, last_done, r, c, z, e);
        check("start_in_run_done_count", done_n, 1);
        check("start_in_run_result", {16'd0, r}, 32'h0406);

        // start held continuously: second accept N+2 cycles after the first
        run_op(OP_ADD, 16'h0001, 16'h0001, 1'b0, 8,
               lat, busy_n, done_n, bad_b, last_done, r, c, z, e);
        check("b2b_done_count", done_n, 2);
        check("b2b_second_done_pos", last_done, 6);
        check("b2b_first_result", {16'd0, r}, 32'h0002);
        check("b2b_second_result", {16'd0, result}, {16'd0, ~16'h0001 + 16'h0001});

        // unsupported oper: err path, result untouched
        prev = result;
        run_op(OP_ROL, 16'h1111, 16'h2222, 1'b1, 1,
               lat, busy_n, done_n, bad_b, last_done, r, c, z, e);
        check("rol_latency", lat, 1);
        check("rol_err", {31'd0, e}, 32'd1);
        check("rol_result_held", {16'd0, r}, {16'd0, prev});
        check("rol_done_count", done_n, 1);

        // async reset in the middle of RUN
        @(negedge clk);
        oper = OP_ADD; a_in = 16'h1111; b_in = 16'h1111; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mid_run_busy_before_reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_run_reset_busy", {31'd0, busy}, 32'd0);
        check("mid_run_reset_result", {16'd0, result}, 32'd0);
        check("mid_run_reset_flags", {29'd0, done, c_out, z_out}, 32'd0);
        check("mid_run_reset_alu_side", {8'd0, alu_oper, alu_flags, alu_a, alu_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_n = 0;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk);
            #1;
            if (done) done_n++;
        end
        check("mid_run_no_done", done_n, 0);
        check("mid_run_result_discarded", {16'd0, result}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
